// File: rtl/padded_window_reader_pkg.sv
// rtl/padded_window_reader_pkg.sv - shared word width, reader FSM states and padded-map geometry helper
package padded_window_reader_pkg;

  localparam int WORD_W = 128;
  localparam int PE     = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} reader_state_t;

  typedef struct packed {
    logic [31:0] cg;
    logic [31:0] wp;
    logic [31:0] oh;
    logic        ok;
  } map_cfg_t;

  // Same geometry the padding write controller uses to lay the map out.
  function automatic map_cfg_t derive_map_cfg(input logic [10:0] ifm_c, input logic [10:0] ifm_w,
                                              input logic padding, input logic stride);
    map_cfg_t c;
    c.cg = 32'(ifm_c >> $clog2(PE));
    c.wp = 32'(ifm_w) + (padding ? 32'd2 : 32'd0);
    c.ok = (c.cg != 32'd0) && (c.wp >= 32'd3);
    c.oh = c.ok ? ((c.wp - 32'd3) >> stride) + 32'd1 : 32'd0;
    return c;
  endfunction

endpackage

// File: rtl/padded_window_reader_out_fifo.sv
// rtl/padded_window_reader_out_fifo.sv - reader_out_fifo: synchronous FIFO for tap words plus sideband flags
module reader_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 130
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/padded_window_reader.sv
// rtl/padded_window_reader.sv - reads the padded IFM buffer and streams 3x3 tap words in compute order
// Optional stall_cnt output when READER_STALL_CNT_EN is defined.
module padded_window_reader
  import padded_window_reader_pkg::*;
#(
  parameter int PE         = padded_window_reader_pkg::PE,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [10:0]     IFM_C,
  input  logic [10:0]     IFM_W,
  input  logic            padding,
  input  logic            stride,
  output logic            rd_en,
  output logic [31:0]     rd_addr,
  input  logic [PE*8-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PE*8-1:0] out_data,
  output logic            out_last_k,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
`ifdef READER_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int WW = PE * 8;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  reader_state_t state;
  map_cfg_t      new_cfg;
  logic [31:0]   cfg_cg, cfg_wp, cfg_oh;
  logic          s;
  logic [1:0]    kx, ky;
  logic [31:0]   cg_i, ow_i, oh_i;
  logic [31:0]   row, col;
  logic [RD_LAT-1:0] pipe_v, pipe_lk, pipe_l;
  logic [7:0]    inflight;
  logic [CW-1:0] fifo_count;
  logic [WW+1:0] fifo_dout;
  logic          pop, last_k_now, last_now;

  assign new_cfg = derive_map_cfg(IFM_C, IFM_W, padding, stride);
  assign pop     = out_valid && out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(pipe_v[i]);
  end

  // A pop this cycle frees a slot, so issue keeps pace with a ready consumer.
  assign rd_en = (state == ISSUE) && ((8'(fifo_count) + inflight < 8'(FIFO_DEPTH)) || pop);

  assign last_k_now = (kx == 2'd2) && (ky == 2'd2);
  assign last_now   = last_k_now && (cg_i == cfg_cg - 32'd1) &&
                      (ow_i == cfg_oh - 32'd1) && (oh_i == cfg_oh - 32'd1);
  assign row        = (oh_i << s) + 32'(ky);
  assign col        = (ow_i << s) + 32'(kx);
  assign rd_addr    = (state == ISSUE) ? (row * cfg_wp + col) * cfg_cg + cg_i : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      cfg_cg  <= '0;
      cfg_wp  <= '0;
      cfg_oh  <= '0;
      s       <= 1'b0;
      kx      <= '0;
      ky      <= '0;
      cg_i    <= '0;
      ow_i    <= '0;
      oh_i    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg_cg <= new_cfg.cg;
          cfg_wp <= new_cfg.wp;
          cfg_oh <= new_cfg.oh;
          s      <= stride;
          kx     <= '0;
          ky     <= '0;
          cg_i   <= '0;
          ow_i   <= '0;
          oh_i   <= '0;
          if (new_cfg.ok) begin
            cfg_err <= 1'b0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end else begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        ISSUE: if (rd_en) begin
          if (kx != 2'd2) kx <= kx + 2'd1;
          else begin
            kx <= '0;
            if (ky != 2'd2) ky <= ky + 2'd1;
            else begin
              ky <= '0;
              if (cg_i != cfg_cg - 32'd1) cg_i <= cg_i + 32'd1;
              else begin
                cg_i <= '0;
                if (ow_i != cfg_oh - 32'd1) ow_i <= ow_i + 32'd1;
                else begin
                  ow_i <= '0;
                  oh_i <= oh_i + 32'd1;
                end
              end
            end
          end
          if (last_now) state <= DRAIN;
        end
        // Leave as the last word is taken so done lands the very next cycle.
        DRAIN: if (inflight == 8'd0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_lk <= '0;
      pipe_l  <= '0;
    end else begin
      pipe_v[0]  <= rd_en;
      pipe_lk[0] <= last_k_now;
      pipe_l[0]  <= last_now;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_lk[i] <= pipe_lk[i-1];
        pipe_l[i]  <= pipe_l[i-1];
      end
    end
  end

  reader_out_fifo #(.DEPTH(FIFO_DEPTH), .W(WW + 2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_v[RD_LAT-1]),
    .push_data ({pipe_l[RD_LAT-1], pipe_lk[RD_LAT-1], rd_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? fifo_dout[WW-1:0] : '0;
  assign out_last_k = out_valid & fifo_dout[WW];
  assign out_last   = out_valid & fifo_dout[WW+1];

`ifdef READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_padded_window_reader.sv
// tb/tb_padded_window_reader.sv - directed bench for padded_window_reader
module tb_padded_window_reader;

  logic         clk = 1'b0;
  logic         rst, start, padding, stride, out_ready;
  logic [10:0]  IFM_C, IFM_W;
  logic         rd_en, out_valid, out_last_k, out_last, busy, done, cfg_err;
  logic [31:0]  rd_addr;
  logic [127:0] rd_data, out_data;
`ifdef READER_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int done_cyc = 0;
  logic done_seen = 1'b0;
  logic busy_at_done = 1'b0;
  logic [31:0]  got_a[$], exp_a[$];
  logic [127:0] got_d[$], exp_d[$];
  logic [1:0]   got_f[$], exp_f[$];
  logic [31:0]  v1 [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  logic [31:0]  v2 [9] = '{2, 3, 4, 8, 9, 10, 14, 15, 16};
  logic [127:0] held;

  always #5 clk = ~clk;

  padded_window_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .IFM_C      (IFM_C),
    .IFM_W      (IFM_W),
    .padding    (padding),
    .stride     (stride),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last_k (out_last_k),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef READER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  function automatic logic [127:0] mk(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, ~a, 32'h0000_1234, a};
  endfunction

  // Buffer model with one cycle of read latency.
  always @(posedge clk) rd_data <= rd_en ? mk(rd_addr) : 128'h0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_en) got_a.push_back(rd_addr);
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_f.push_back({out_last_k, out_last});
      pop_cyc = cyc;
    end
    if (done && !done_seen) begin
      done_seen    = 1'b1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_a.delete();
    got_d.delete();
    got_f.delete();
    done_seen = 1'b0;
  endtask

  task automatic build_exp(input int c, input int w, input int p, input int s);
    int cg_n, wp, oh_n, st;
    logic [31:0] a;
    cg_n = c / 16;
    wp   = w + 2 * p;
    st   = s + 1;
    oh_n = (wp - 3) / st + 1;
    exp_a.delete();
    exp_d.delete();
    exp_f.delete();
    for (int oy = 0; oy < oh_n; oy++)
      for (int ox = 0; ox < oh_n; ox++)
        for (int g = 0; g < cg_n; g++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              a = 32'(((oy * st + ky) * wp + ox * st + kx) * cg_n + g);
              exp_a.push_back(a);
              exp_d.push_back(mk(a));
              exp_f.push_back({(kx == 2 && ky == 2),
                               (oy == oh_n - 1 && ox == oh_n - 1 && g == cg_n - 1 && ky == 2 && kx == 2)});
            end
  endtask

  task automatic do_start(input int c, input int w, input logic p, input logic s);
    IFM_C   = 11'(c);
    IFM_W   = 11'(w);
    padding = p;
    stride  = s;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      step();
      n++;
    end
    chk({tag, " done_seen"}, done_seen, 1'b1);
  endtask

  task automatic wait_words(input string tag, input int k);
    int n = 0;
    while (got_d.size() < k && n < 200) begin
      step();
      n++;
    end
    chk({tag, " reach_words"}, (got_d.size() >= k), 1'b1);
  endtask

  task automatic compare_run(input string tag);
    chk({tag, " n_rd"}, got_a.size(), exp_a.size());
    chk({tag, " n_out"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), got_a[i], exp_a[i]);
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s data%0d", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s flags%0d", tag, i), got_f[i], exp_f[i]);
    end
    chk({tag, " done_lat"}, done_cyc, pop_cyc + 1);
    chk({tag, " busy_at_done"}, busy_at_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; IFM_C = '0; IFM_W = '0;
    padding = 1'b0; stride = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst cfg_err", cfg_err, 1'b0);
    chk("rst rd_en", rd_en, 1'b0);
    chk("rst rd_addr", rd_addr, 32'd0);
    chk("rst out_data", out_data, 128'd0);

    // C=16 W=4 pad=1 stride 1: 144 words, check start-up latency
    clear_mon();
    build_exp(16, 4, 1, 0);
    do_start(16, 4, 1'b1, 1'b0);
    chk("t1 busy", busy, 1'b1);
    chk("t1 rd_en", rd_en, 1'b1);
    chk("t1 addr0", rd_addr, 32'd0);
    chk("t1 lat0", out_valid, 1'b0);
    step();
    chk("t1 lat1", out_valid, 1'b0);
    step();
    chk("t1 lat2", out_valid, 1'b1);
    wait_done("t1", 400);
    chk("t1 words", got_d.size(), 144);
    for (int i = 0; i < 9; i++) chk($sformatf("t1 hand%0d", i), got_a[i], v1[i]);
    chk("t1 win2", got_a[9], 32'd1);
    chk("t1 last", got_f[143], 2'b11);
    compare_run("t1");

    // stride 2, with an ignored start in the middle
    clear_mon();
    build_exp(16, 4, 1, 1);
    do_start(16, 4, 1'b1, 1'b1);
    step();
    step();
    do_start(32, 3, 1'b0, 1'b0);
    chk("t2 busy_kept", busy, 1'b1);
    wait_done("t2", 200);
    chk("t2 words", got_d.size(), 36);
    for (int i = 0; i < 9; i++) chk($sformatf("t2 hand%0d", i), got_a[9 + i], v2[i]);
    compare_run("t2");

    // two channel groups
    clear_mon();
    build_exp(32, 3, 0, 0);
    do_start(32, 3, 1'b0, 1'b0);
    wait_done("t3", 100);
    chk("t3 words", got_d.size(), 18);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3 cg0_%0d", i), got_a[i], 32'(2 * i));
      chk($sformatf("t3 cg1_%0d", i), got_a[9 + i], 32'(2 * i + 1));
    end
    chk("t3 lastk9", got_f[8], 2'b10);
    chk("t3 last18", got_f[17], 2'b11);
    compare_run("t3");

    // backpressure for 5 cycles mid-stream
    clear_mon();
    build_exp(16, 4, 1, 0);
    do_start(16, 4, 1'b1, 1'b0);
    wait_words("t4", 20);
    out_ready = 1'b0;
    chk("t4 valid_at_stall", out_valid, 1'b1);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4 stable%0d", k), out_data, held);
      chk($sformatf("t4 valid%0d", k), out_valid, 1'b1);
      if (k >= 2) chk($sformatf("t4 rd_off%0d", k), rd_en, 1'b0);
      step();
    end
`ifdef READER_STALL_CNT_EN
    chk("t4 stall_cnt", stall_cnt, 32'd5);
`endif
    out_ready = 1'b1;
    wait_done("t4", 400);
    compare_run("t4");

    // reset mid-map, then replay from address 0
    clear_mon();
    do_start(16, 4, 1'b1, 1'b0);
    wait_words("t5", 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5 valid_after_rst", out_valid, 1'b0);
    chk("t5 busy_after_rst", busy, 1'b0);
    chk("t5 rd_en_after_rst", rd_en, 1'b0);
    clear_mon();
    build_exp(16, 4, 1, 0);
    do_start(16, 4, 1'b1, 1'b0);
    wait_done("t5", 400);
    compare_run("t5");

    // invalid configurations
    clear_mon();
    do_start(0, 4, 1'b0, 1'b0);
    chk("t6 c0 cfg_err", cfg_err, 1'b1);
    chk("t6 c0 done", done, 1'b1);
    chk("t6 c0 busy", busy, 1'b0);
    repeat (4) step();
    chk("t6 c0 sticky", cfg_err, 1'b1);
    chk("t6 c0 done_pulse", done, 1'b0);
    do_start(16, 1, 1'b0, 1'b0);
    chk("t6 w1 cfg_err", cfg_err, 1'b1);
    chk("t6 w1 done", done, 1'b1);
    repeat (4) step();
    chk("t6 no_reads", got_a.size(), 0);
    clear_mon();
    build_exp(32, 3, 0, 0);
    do_start(32, 3, 1'b0, 1'b0);
    chk("t6 cfg_err_cleared", cfg_err, 1'b0);
    wait_done("t6", 100);
    compare_run("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
